// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and the
// default bit period for the 9600 baud debug link.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int BOARD_CLK_HZ    = 10_416_000;
  localparam int DEBUG_BAUD      = 9600;
  localparam int DEFAULT_CLK_DIV = BOARD_CLK_HZ / DEBUG_BAUD;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each period.
// Shared between the transmitter and the future receiver.
module uart_baud_gen #(
  parameter int CLK_DIV = 1085
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Not gated by clear: the transmitter's ready depends on tick, and clear on ready.
  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits. Define UART_TX_BREAK_EN to add the tx_break line-break input.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 TxD
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV=%0d outside 2..65535", CLK_DIV);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY=%0d is not 0, 1 or 2", PARITY);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
  end

  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic       ODD_PARITY = (PARITY == PARITY_ODD);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_idx;
  logic                 r_parity;
  logic                 r_txd;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_last_stop;
  logic                 w_break;
  logic                 w_clear;

`ifdef UART_TX_BREAK_EN
  assign w_break = tx_break;
`else
  assign w_break = 1'b0;
`endif

  // A pending break outranks a new payload at the end of the frame.
  assign w_last_stop = (r_state == TX_STOP) && (r_bit_idx == LAST_STOP) && w_tick;
  assign tx_ready    = !w_break && ((r_state == TX_IDLE) || w_last_stop);
  assign w_accept    = tx_valid && tx_ready;
  assign busy        = (r_state != TX_IDLE);
  assign tx_done     = w_last_stop;
  assign TxD         = r_txd;
  assign w_clear     = w_accept || (r_state == TX_IDLE) || (r_state == TX_BREAK);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
    end else if (w_accept) begin
      r_state   <= TX_START;
      r_shift   <= tx_data;
      r_bit_idx <= '0;
      r_parity  <= (^tx_data) ^ ODD_PARITY;
      r_txd     <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_break) begin
            r_state <= TX_BREAK;
            r_txd   <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tick) begin
            r_state <= TX_DATA;
            r_txd   <= r_shift[0];
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
              if (HAS_PARITY) begin
                r_state <= TX_PARITY;
                r_txd   <= r_parity;
              end else begin
                r_state <= TX_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            r_state <= TX_STOP;
            r_txd   <= 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_STOP) begin
              r_bit_idx <= '0;
              if (w_break) begin
                r_state <= TX_BREAK;
                r_txd   <= 1'b0;
              end else begin
                r_state <= TX_IDLE;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        TX_BREAK: begin
          if (!w_break) begin
            r_state <= TX_IDLE;
            r_txd   <= 1'b1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at CLK_DIV=4.
// Stimulus pushes expected frames; a monitor samples TxD mid-bit and pops/compares.
`timescale 1ns/1ps
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int CD     = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PB [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
  localparam int SB [4] = '{1, 1, 1, 2};

  typedef struct {
    int          inst;
    logic [15:0] bits;
  } exp_t;

  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [15:0] frame;
    int          len;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] td [4];
  logic [3:0] tv;
  logic [3:0] mon_en;
`ifdef UART_TX_BREAK_EN
  logic [3:0] tb_brk;
`endif
  wire  [3:0] txd;
  wire  [3:0] rdy;
  wire  [3:0] bsy;
  wire  [3:0] dne;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt [4] = '{default: 0};
  exp_t sb_q [$];

  // Frames are bit i = i-th bit on the line (bit 0 = start bit), hand-computed.
  vec_t vt [5] = '{
    '{0, 9'h0A5, 16'h034A, 40},   // 8N1 A5: 0,1,0,1,0,0,1,0,1,1
    '{1, 9'h0A5, 16'h054A, 44},   // 8E1 A5: parity 0
    '{2, 9'h0A5, 16'h074A, 44},   // 8O1 A5: parity 1
    '{1, 9'h001, 16'h0602, 44},   // 8E1 01: parity 1
    '{3, 9'h07F, 16'h03FE, 40}    // 7N2 7F: seven ones, two stops
  };

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    uart_tx_param #(
      .CLK_DIV   (CD),
      .DATA_BITS (DB[gi]),
      .PARITY    (PB[gi]),
      .STOP_BITS (SB[gi])
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .tx_data  (td[gi][DB[gi]-1:0]),
      .tx_valid (tv[gi]),
`ifdef UART_TX_BREAK_EN
      .tx_break (tb_brk[gi]),
`endif
      .tx_ready (rdy[gi]),
      .busy     (bsy[gi]),
      .tx_done  (dne[gi]),
      .TxD      (txd[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int nbits(input int i);
    return 1 + DB[i] + ((PB[i] != PARITY_NONE) ? 1 : 0) + SB[i];
  endfunction

  task automatic push(input int inst, input logic [15:0] bits);
    exp_t e;
    e.inst = inst;
    e.bits = bits;
    sb_q.push_back(e);
  endtask

  // Returns #1 after the accepting edge; waited counts negedges spent waiting for ready.
  task automatic send(input int idx, input logic [8:0] d, input bit keep, output int waited);
    waited  = 0;
    td[idx] = d;
    tv[idx] = 1'b1;
    while (rdy[idx] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (rdy[idx] !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      tv[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    $display("send: inst %0d data %0h after %0d wait cycles", idx, d, waited);
    if (!keep) tv[idx] = 1'b0;
    td[idx] = ~d;
  endtask

  task automatic watch(input int idx, input int ncyc, output int done_at, output int n_done,
                       output int rdy_first, output int rdy_n);
    done_at = -1; n_done = 0; rdy_first = -1; rdy_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (dne[idx] === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (rdy[idx] === 1'b1) begin
        rdy_n++;
        if (rdy_first < 0) rdy_first = c;
      end
    end
  endtask

  initial begin : done_counter
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (dne[i] === 1'b1) done_cnt[i]++;
    end
  end

  initial begin : monitor
    bit          act [4];
    int          cyc [4];
    int          nb  [4];
    logic [15:0] got [4];
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b0; cyc[i] = 0; nb[i] = 0; got[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0;
        end else if (!act[i]) begin
          if (mon_en[i] && txd[i] === 1'b0) begin
            act[i] = 1'b1; cyc[i] = 0; nb[i] = 0; got[i] = '0;
          end
        end else begin
          cyc[i]++;
          if (cyc[i] % CD == CD / 2) begin
            got[i][nb[i]] = txd[i];
            nb[i]++;
            if (nb[i] == nbits(i)) begin
              act[i] = 1'b0;
              $display("frame: inst %0d line bits %0h", i, got[i]);
              if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: inst %0d got frame %0h, required none", i, got[i]);
              end else begin
                e = sb_q.pop_front();
                chk("sb_frame {inst,bits}", {8'(i), got[i]}, {8'(e.inst), e.bits});
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w, done_at, n_done, rf, rn, d0, lo, rlo;
    tv     = '0;
    mon_en = '1;
    for (int i = 0; i < 4; i++) td[i] = '0;
`ifdef UART_TX_BREAK_EN
    tb_brk = '0;
`endif
    #1 rst_n = 1'b0;
    #11;
    chk("reset_txd",   32'(txd), 32'hF);
    chk("reset_ready", 32'(rdy), 32'hF);
    chk("reset_busy",  32'(bsy), 32'h0);
    chk("reset_done",  32'(dne), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames across all four configurations
    foreach (vt[k]) begin
      push(vt[k].inst, vt[k].frame);
      send(vt[k].inst, vt[k].data, 1'b0, w);
      watch(vt[k].inst, vt[k].len, done_at, n_done, rf, rn);
      chk($sformatf("v%0d_done_cycle", k),  done_at, vt[k].len);
      chk($sformatf("v%0d_done_count", k),  n_done, 1);
      chk($sformatf("v%0d_ready_first", k), rf, vt[k].len);
      chk($sformatf("v%0d_ready_cycles", k), rn, 1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", k), bsy[vt[k].inst], 0);
      chk($sformatf("v%0d_idle_txd", k),  txd[vt[k].inst], 1);
    end

    // Back-to-back with tx_valid held high
    d0 = done_cnt[0];
    push(0, 16'h02AA);
    push(0, 16'h0354);
    send(0, 9'h055, 1'b1, w);
    send(0, 9'h0AA, 1'b0, w);
    chk("b2b_accept_cycle", w, 40);
    @(negedge clk);
    chk("b2b_second_start", txd[0], 0);
    repeat (40) @(negedge clk);
    chk("b2b_done_pulses", done_cnt[0] - d0, 2);
    chk("b2b_idle_busy", bsy[0], 0);

    // Asynchronous reset in DATA bit 3, then a clean frame
    push(0, 16'h034A);
    send(0, 9'h0A5, 1'b0, w);
    repeat (18) @(negedge clk);
    chk("pre_reset_txd_bit3", txd[0], 0);
    d0 = done_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd",   txd[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_busy",  bsy[0], 0);
    chk("abort_done",  dne[0], 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done_cnt[0] - d0, 0);
    push(0, 16'h0278);
    send(0, 9'h03C, 1'b0, w);
    watch(0, 40, done_at, n_done, rf, rn);
    chk("post_reset_done_cycle", done_at, 40);
    @(negedge clk);

`ifdef UART_TX_BREAK_EN
    // Break in IDLE for 20 cycles
    mon_en[0] = 1'b0;
    tb_brk[0] = 1'b1;
    lo = 0; rlo = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (txd[0] === 1'b0) lo++;
      if (rdy[0] === 1'b0) rlo++;
    end
    tb_brk[0] = 1'b0;
    chk("brk_txd_low_cycles", lo, 20);
    chk("brk_ready_low_cycles", rlo, 20);
    @(negedge clk);
    chk("brk_end_txd",   txd[0], 1);
    chk("brk_end_ready", rdy[0], 1);
    chk("brk_end_busy",  bsy[0], 0);
    mon_en[0] = 1'b1;

    // Break raised mid-frame waits for the stop bit
    push(0, 16'h02AA);
    send(0, 9'h055, 1'b0, w);
    repeat (10) @(negedge clk);
    tb_brk[0] = 1'b1;
    mon_en[0] = 1'b0;
    watch(0, 30, done_at, n_done, rf, rn);
    chk("brk_mid_done_cycle", done_at, 30);
    chk("brk_mid_ready_cycles", rn, 0);
    @(negedge clk);
    chk("brk_mid_txd",  txd[0], 0);
    chk("brk_mid_busy", bsy[0], 1);
    repeat (3) @(negedge clk);
    tb_brk[0] = 1'b0;
    @(negedge clk);
    chk("brk_mid_end_txd", txd[0], 1);
    mon_en[0] = 1'b1;
`endif

    repeat (5) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter; next generation of the fixed 8N1/9600 serial transmitter used on the board-level debug/control link. Configurable bit period, data width, parity and stop-bit count. Accepts bytes over a valid/ready handshake and raises a frame-done pulse. Sits between a host-side byte source (command/packet logic) and the TxD pin.

Parameters:
CLK_DIV, 1085, clock cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  payload, LSB transmitted first
tx_valid  in  1  source has a payload on tx_data
tx_ready  out  1  block can accept a payload this cycle
busy  out  1  frame in progress (any state other than IDLE)
tx_done  out  1  one-cycle pulse at the end of the final stop bit
TxD  out  1  serial line, idle high

Behaviour:
- Reset (reset low, asynchronous): TxD=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0. Mid-frame reset aborts the frame; TxD goes high immediately with no clock edge; no tx_done.
- Accept: transfer occurs on a posedge where tx_valid && tx_ready. tx_data is latched into the shift register. Parity is computed from the latched value. tx_data changes after acceptance are ignored.
- tx_ready = 1 in IDLE, and in the last clk cycle of the final stop bit. It is 0 at all other times.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or START).
  - START drives TxD=0.
  - DATA drives shift[0] and shifts right each bit period. bit_idx runs 0..DATA_BITS-1.
  - PARITY drives XOR of the data bits, inverted if PARITY=2. It is skipped when PARITY=0.
  - STOP drives TxD=1 for STOP_BITS periods.
- Timing: the start bit begins on the cycle after acceptance. The baud counter is cleared on acceptance. Every bit lasts exactly CLK_DIV cycles; no fractional drift.
- Frame length = CLK_DIV * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Back-to-back: if a transfer occurs in the last stop cycle, the next START follows with zero idle gap. tx_done still pulses in that cycle.
- tx_done asserts for exactly one cycle: the last cycle of the final stop bit.
- TxD is registered; no combinational path from tx_valid or tx_data to TxD.
- Counter widths: baud counter $clog2(CLK_DIV) bits, wrapping at CLK_DIV-1. bit counter 4 bits.
- Illegal parameter values: the block stops elaboration with $error.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port tx_break (1 bit).
  - tx_break asserted in IDLE forces TxD=0, holds tx_ready=0 and busy=1 while asserted.
  - The block returns to IDLE with TxD=1 on the cycle after deassertion.
  - tx_break asserted mid-frame is deferred until the frame completes, then takes effect instead of accepting a new payload.
- Undefined: no tx_break port; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PARITY_NONE/EVEN/ODD;
  - the tx state enum typedef (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the default CLK_DIV for 9600 baud at the board clock.
- One sub-module, uart_baud_gen. Parameters: CLK_DIV. Inputs: clk, reset, clear. Output: one-cycle tick at counter wrap. It will be reused by the future receiver.

Test Plan:
- CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 -> TxD sampled mid-bit = 0,1,0,1,0,0,1,0,1,1. Frame lasts 40 cycles. tx_done pulses in cycle 40 after acceptance.
- PARITY=1, then PARITY=2, payload 0xA5 -> parity bit 0 (even) and 1 (odd). Payload 0x01 -> 1 (even) and 0 (odd).
- tx_valid held high with 0x55 then 0xAA -> second start bit immediately follows the first stop bit. No idle cycle. Exactly two tx_done pulses.
- STOP_BITS=2, DATA_BITS=7, payload 0x7F -> seven 1 bits, then two stop periods of CLK_DIV cycles each. tx_ready asserts only in the final cycle.
- Reset asserted during the DATA bit 3 period -> TxD=1 asynchronously, tx_ready=1, busy=0, no tx_done. A new send after release starts a clean frame.
- With UART_TX_BREAK_EN: tx_break held 20 cycles in IDLE -> TxD=0 for 20 cycles, tx_ready=0. tx_break asserted mid-frame -> break starts only after the stop bit.
